// File: rtl/dac_2ch_arbiter.sv
// -----------------------------------------------------------------------------
// dac_2ch_arbiter
//
// Shares one SPI write engine between two DAC channels (A and B). A level
// request per channel is arbitrated in IDLE. The winner's code is packed into a
// 16-bit DAC command word and a start pulse is issued. The arbiter then waits
// for the engine's end-of-data pulse, acknowledges the winner, and enforces a
// minimum CS-high gap before the next frame.
//
// Frame timeline in clock edges, counted from the edge that grants in IDLE:
//   +0          word_o loaded, busy_o rises
//   +1          start_o pulses (registered image of the START state)
//   eod edge    ack_o pulses for the winner
//   +GAP_CYC    busy_o falls
//
// Configuration macro:
//   DAC_RR_ARB_EN  defined   -> round-robin arbitration (last-grant pointer)
//                  undefined -> fixed priority, channel A always wins
//
// Parameters:
//   DW       DAC code width (code is zero-extended/truncated to 12 bits)
//   GAP_CYC  idle cycles between frames, 1..255
//
// Ports:
//   clk_i    system clock, rising edge
//   rst_i    asynchronous active-low reset
//   req_i    per-channel level request (bit0 = A, bit1 = B)
//   data0_i  channel A code, sampled on grant
//   data1_i  channel B code, sampled on grant
//   eod_i    end-of-data pulse from the SPI write engine
//   start_o  one-cycle start pulse to the SPI write engine
//   word_o   DAC command word, stable for the whole frame
//   ack_o    one-hot, one-cycle completion pulse per channel
//   busy_o   high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module dac_2ch_arbiter #(
    parameter int DW      = 12,
    parameter int GAP_CYC = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [1:0]    req_i,
    input  logic [DW-1:0] data0_i,
    input  logic [DW-1:0] data1_i,
    input  logic          eod_i,
    output logic          start_o,
    output logic [15:0]   word_o,
    output logic [1:0]    ack_o,
    output logic          busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    localparam logic [7:0] GAP_LAST = 8'(GAP_CYC - 1);

    state_t      state_r;
    state_t      next_s;
    logic [7:0]  gap_cnt_r;
    logic        start_r;
    logic        busy_r;
    logic [1:0]  ack_r;
    logic [15:0] word_r;
    logic        grant_s;
    logic        grant_ch_s;
    logic [11:0] code_s;

    // DAC command word: channel select, unbuffered Vref, 1x gain, output active.
    function automatic logic [15:0] dac_word(input logic ch, input logic [11:0] code);
        return {ch, 1'b0, 1'b1, 1'b1, code};
    endfunction

`ifdef DAC_RR_ARB_EN
    logic last_r;   // channel granted most recently (0 = A, 1 = B)

    // Round-robin pick: on a tie the channel not granted last wins.
    always_comb begin
        if (req_i == 2'b11) begin
            grant_ch_s = ~last_r;
        end else if (req_i[0]) begin
            grant_ch_s = 1'b0;
        end else begin
            grant_ch_s = 1'b1;
        end
    end

    // Last-grant pointer; resets to B so that A wins the first tie.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            last_r <= 1'b1;
        end else if (grant_s) begin
            last_r <= grant_ch_s;
        end else begin
            last_r <= last_r;
        end
    end
`else
    // Fixed priority pick: A whenever it requests.
    always_comb begin
        if (req_i[0]) begin
            grant_ch_s = 1'b0;
        end else begin
            grant_ch_s = 1'b1;
        end
    end
`endif

    // Grant qualification and winner code selection.
    always_comb begin
        grant_s = (state_r == ST_IDLE) && (req_i != 2'b00);
        if (grant_ch_s) begin
            code_s = 12'(data1_i);
        end else begin
            code_s = 12'(data0_i);
        end
    end

    // Next-state logic; eod_i only matters in WAIT.
    always_comb begin
        next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_i != 2'b00) begin
                    next_s = ST_START;
                end else begin
                    next_s = ST_IDLE;
                end
            end
            ST_START: begin
                next_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (eod_i) begin
                    next_s = ST_GAP;
                end else begin
                    next_s = ST_WAIT;
                end
            end
            ST_GAP: begin
                if (gap_cnt_r == GAP_LAST) begin
                    next_s = ST_IDLE;
                end else begin
                    next_s = ST_GAP;
                end
            end
            default: begin
                next_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Registered outputs and gap counter.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            start_r   <= 1'b0;
            busy_r    <= 1'b0;
            ack_r     <= 2'b00;
            word_r    <= 16'h0000;
            gap_cnt_r <= 8'd0;
        end else begin
            start_r <= (state_r == ST_START);
            busy_r  <= (next_s != ST_IDLE);

            // word_r[15] records the winner for the whole frame.
            if (state_r == ST_WAIT && eod_i) begin
                ack_r <= word_r[15] ? 2'b10 : 2'b01;
            end else begin
                ack_r <= 2'b00;
            end

            if (grant_s) begin
                word_r <= dac_word(grant_ch_s, code_s);
            end else begin
                word_r <= word_r;
            end

            if (state_r == ST_GAP && gap_cnt_r != GAP_LAST) begin
                gap_cnt_r <= gap_cnt_r + 8'd1;
            end else begin
                gap_cnt_r <= 8'd0;
            end
        end
    end

    assign start_o = start_r;
    assign word_o  = word_r;
    assign ack_o   = ack_r;
    assign busy_o  = busy_r;

endmodule

// File: tb/tb_dac_2ch_arbiter.sv
// -----------------------------------------------------------------------------
// Bench for dac_2ch_arbiter. A frame-timeline model (grant edge, eod edge,
// gap length) predicts every output on every clock; directed scenarios pin the
// model with hand-computed literal words, acks and spacings; a randomized
// phase with occasional resets follows.
// -----------------------------------------------------------------------------
module tb_dac_2ch_arbiter;

    localparam int DW  = 12;
    localparam int GAP = 4;
    localparam int BIG = 1 << 30;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic [1:0]    req_i = 2'b00;
    logic [DW-1:0] data0_i = '0;
    logic [DW-1:0] data1_i = '0;
    logic          eod_i = 1'b0;
    logic          start_o;
    logic [15:0]   word_o;
    logic [1:0]    ack_o;
    logic          busy_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    dac_2ch_arbiter #(.DW(DW), .GAP_CYC(GAP)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .req_i   (req_i),
        .data0_i (data0_i),
        .data1_i (data1_i),
        .eod_i   (eod_i),
        .start_o (start_o),
        .word_o  (word_o),
        .ack_o   (ack_o),
        .busy_o  (busy_o)
    );

    // ---------------- model state: frame timeline ----------------
    int          n = 0;            // posedge count
    int          ng = -100;        // edge of last grant
    int          ne = -100;        // edge at which eod was accepted
    int          idle_from = 0;    // edges after which arbiter is idle
    bit          waiting = 1'b0;   // granted, eod not yet accepted
    bit          chm = 1'b0;       // current winner
    bit          lastb = 1'b1;     // last granted channel
    logic [15:0] wexp = 16'h0000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, n);
        end
    endtask

    always @(posedge clk_i) begin : model
        logic [1:0]  r;
        logic        e;
        logic        rs;
        logic [11:0] d0;
        logic [11:0] d1;
        r  = req_i;
        e  = eod_i;
        rs = rst_i;
        d0 = data0_i;
        d1 = data1_i;
        n++;
        if (!rs) begin
            ng = -100; ne = -100; idle_from = n; waiting = 1'b0;
            lastb = 1'b1; wexp = 16'h0000;
        end else if (waiting) begin
            if (e && n >= ng + 2) begin
                ne = n; idle_from = n + GAP; waiting = 1'b0;
            end
        end else if (n > idle_from && r != 2'b00) begin
            if (r == 2'b11) begin
`ifdef DAC_RR_ARB_EN
                chm = !lastb;
`else
                chm = 1'b0;
`endif
            end else begin
                chm = (r == 2'b10);
            end
            lastb = chm;
            ng = n; ne = -100; waiting = 1'b1; idle_from = BIG;
            wexp = {chm, 3'b011, (chm ? d1 : d0)};
        end
        #1;
        chk("start", {31'd0, start_o}, {31'd0, n == ng + 1});
        chk("word", {16'd0, word_o}, {16'd0, wexp});
        chk("ack", {30'd0, ack_o}, (n == ne) ? (chm ? 32'd2 : 32'd1) : 32'd0);
        chk("busy", {31'd0, busy_o}, {31'd0, n < idle_from});
    end

    // ---------------- event log ----------------
    logic [15:0] sw_q[$];
    int          sn_q[$];
    logic [1:0]  ak_q[$];
    int          an_q[$];

    always @(negedge clk_i) begin
        if (rst_i) begin
            if (start_o) begin
                sw_q.push_back(word_o);
                sn_q.push_back(n);
            end
            if (ack_o != 2'b00) begin
                ak_q.push_back(ack_o);
                an_q.push_back(n);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    bit auto_eod = 1'b0;
    bit auto_clr = 1'b0;
    int ecnt = 0;

    task automatic cyc();
        @(negedge clk_i);
        if (auto_eod) begin
            if (start_o) begin
                ecnt = 2; eod_i = 1'b0;
            end else if (ecnt == 1) begin
                eod_i = 1'b1; ecnt = 0;
            end else begin
                eod_i = 1'b0;
                if (ecnt > 1) ecnt--;
            end
        end
        if (auto_clr) req_i = req_i & ~ack_o;
    endtask

    task automatic do_reset();
        auto_eod = 1'b0; auto_clr = 1'b0; ecnt = 0;
        req_i = 2'b00; eod_i = 1'b0; rst_i = 1'b0;
        cyc();
        cyc();
        rst_i = 1'b1;
    endtask

    task automatic wait_acks(input int base, input int k, input int budget);
        int t;
        t = 0;
        while ((ak_q.size() - base) < k && t < budget) begin
            cyc();
            t++;
        end
        chk("frames_done", ak_q.size() - base, k);
    endtask

    task automatic drain();
        req_i = 2'b00;
        repeat (14) cyc();
    endtask

    logic [15:0] exp_w[4];
    logic [15:0] wtmp;
    int sb;
    int ab;

    initial begin
        // ---- reset values and first cycle after release ----
        do_reset();
        chk("rst_start", {31'd0, start_o}, 32'd0);
        chk("rst_word", {16'd0, word_o}, 32'h0000);
        chk("rst_ack", {30'd0, ack_o}, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        cyc();
        chk("post_rst_start", {31'd0, start_o}, 32'd0);
        chk("post_rst_ack", {30'd0, ack_o}, 32'd0);

        // ---- single A frame with exact timing ----
        do_reset();
        req_i = 2'b01; data0_i = 12'hABC;
        cyc();
        chk("t1_start_c1", {31'd0, start_o}, 32'd0);
        cyc();
        chk("t1_start_c2", {31'd0, start_o}, 32'd1);
        chk("t1_word", {16'd0, word_o}, 32'h3ABC);
        eod_i = 1'b1;
        cyc();
        eod_i = 1'b0;
        chk("t1_ack", {30'd0, ack_o}, 32'd1);
        req_i = 2'b00;
        repeat (3) cyc();
        chk("t1_busy_gap_end", {31'd0, busy_o}, 32'd1);
        cyc();
        chk("t1_busy_low", {31'd0, busy_o}, 32'd0);
        drain();

        // ---- simultaneous requests, each released on its ack ----
        do_reset();
        data0_i = 12'h100; data1_i = 12'h200;
        auto_eod = 1'b1; auto_clr = 1'b1;
        sb = sw_q.size(); ab = ak_q.size();
        req_i = 2'b11;
        wait_acks(ab, 2, 80);
        if (sw_q.size() >= sb + 2 && ak_q.size() >= ab + 2) begin
            chk("t2_word0", {16'd0, sw_q[sb]}, 32'h3100);
            chk("t2_word1", {16'd0, sw_q[sb+1]}, 32'hB200);
            chk("t2_ack0", {30'd0, ak_q[ab]}, 32'd1);
            chk("t2_ack1", {30'd0, ak_q[ab+1]}, 32'd2);
            chk("t2_spacing", sn_q[sb+1] - an_q[ab], GAP + 2);
        end
        drain();

        // ---- requests held for four frames ----
`ifdef DAC_RR_ARB_EN
        exp_w[0] = 16'h3100; exp_w[1] = 16'hB200; exp_w[2] = 16'h3100; exp_w[3] = 16'hB200;
`else
        exp_w[0] = 16'h3100; exp_w[1] = 16'h3100; exp_w[2] = 16'h3100; exp_w[3] = 16'h3100;
`endif
        do_reset();
        auto_eod = 1'b1;
        sb = sw_q.size(); ab = ak_q.size();
        req_i = 2'b11;
        wait_acks(ab, 4, 160);
        req_i = 2'b00;
        for (int i = 0; i < 4; i++) begin
            if (sw_q.size() > sb + i && ak_q.size() > ab + i) begin
                wtmp = sw_q[sb+i];
                chk("t3_word", {16'd0, wtmp}, {16'd0, exp_w[i]});
                chk("t3_ack", {30'd0, ak_q[ab+i]}, wtmp[15] ? 32'd2 : 32'd1);
            end
        end
        drain();

        // ---- reset during WAIT on channel B ----
        do_reset();
        req_i = 2'b10; data1_i = 12'h5A5;
        cyc();
        cyc();
        chk("t4_start", {31'd0, start_o}, 32'd1);
        chk("t4_word", {16'd0, word_o}, 32'hB5A5);
        ab = ak_q.size();
        rst_i = 1'b0;
        cyc();
        chk("t4_in_rst_busy", {31'd0, busy_o}, 32'd0);
        chk("t4_in_rst_word", {16'd0, word_o}, 32'h0000);
        rst_i = 1'b1;
        cyc();
        chk("t4_rel_start", {31'd0, start_o}, 32'd0);
        chk("t4_rel_ack", {30'd0, ack_o}, 32'd0);
        cyc();
        chk("t4_restart", {31'd0, start_o}, 32'd1);
        chk("t4_reword", {16'd0, word_o}, 32'hB5A5);
        chk("t4_no_ack", ak_q.size() - ab, 0);
        eod_i = 1'b1;
        cyc();
        eod_i = 1'b0;
        chk("t4_ack", {30'd0, ack_o}, 32'd2);
        drain();

        // ---- eod in IDLE and in GAP is ignored ----
        do_reset();
        eod_i = 1'b1;
        cyc();
        eod_i = 1'b0;
        chk("t5_idle_ack", {30'd0, ack_o}, 32'd0);
        chk("t5_idle_busy", {31'd0, busy_o}, 32'd0);
        req_i = 2'b01; data0_i = 12'h00F;
        cyc();
        cyc();
        eod_i = 1'b1;
        cyc();
        eod_i = 1'b0; req_i = 2'b00;
        chk("t5_ack", {30'd0, ack_o}, 32'd1);
        cyc();
        eod_i = 1'b1;
        cyc();
        eod_i = 1'b0;
        chk("t5_gap_ack", {30'd0, ack_o}, 32'd0);
        chk("t5_gap_busy", {31'd0, busy_o}, 32'd1);
        cyc();
        cyc();
        chk("t5_gap_len", {31'd0, busy_o}, 32'd0);
        drain();

        // ---- request dropped after grant still completes ----
        do_reset();
        req_i = 2'b01; data0_i = 12'h123;
        cyc();
        req_i = 2'b00;
        cyc();
        chk("t6_word", {16'd0, word_o}, 32'h3123);
        eod_i = 1'b1;
        cyc();
        eod_i = 1'b0;
        chk("t6_ack", {30'd0, ack_o}, 32'd1);
        drain();

        // ---- A request dropped while busy on B is never served ----
        do_reset();
        req_i = 2'b10;
        cyc();
        cyc();
        req_i = 2'b11;
        cyc();
        req_i = 2'b10; eod_i = 1'b1;
        cyc();
        eod_i = 1'b0;
        chk("t6b_ack", {30'd0, ack_o}, 32'd2);
        req_i = 2'b00;
        sb = sw_q.size();
        repeat (15) cyc();
        chk("t6b_no_frame", sw_q.size() - sb, 0);

        // ---- randomized traffic, checked by the model every cycle ----
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            cyc();
            if ($urandom_range(7, 0) == 0) req_i[0] = ~req_i[0];
            if ($urandom_range(7, 0) == 0) req_i[1] = ~req_i[1];
            eod_i   = ($urandom_range(5, 0) == 0);
            data0_i = DW'($urandom);
            data1_i = DW'($urandom);
            rst_i   = ($urandom_range(499, 0) != 0);
        end
        rst_i = 1'b1; eod_i = 1'b0;
        auto_eod = 1'b1;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dac_2ch_arbiter.md
DAC_2CH_ARBITER -- requirements
Module: dac_2ch_arbiter

Interface
REQ-001 Parameter DW, default 12: DAC code width.
REQ-002 Parameter GAP_CYC, default 4: idle clk cycles between SPI frames (CS-high minimum), range 1..255.
REQ-003 clk_i  input  1  system clock, 100 MHz, rising edge.
REQ-004 rst_i  input  1  asynchronous, active-low reset.
REQ-005 req_i  input  2  per-channel write request, level; bit0 = ch A, bit1 = ch B; held until matching ack_o.
REQ-006 data0_i  input  DW  ch A code, sampled on grant.
REQ-007 data1_i  input  DW  ch B code, sampled on grant.
REQ-008 eod_i  input  1  one-cycle end-of-data pulse from SPI write engine.
REQ-009 start_o  output  1  one-cycle start pulse to SPI write engine.
REQ-010 word_o  output  16  DAC command word to SPI write engine.
REQ-011 ack_o  output  2  one-cycle completion pulse, one-hot per channel.
REQ-012 busy_o  output  1  high in every state except IDLE.

Function
REQ-013 The block shall implement FSM states IDLE, START, WAIT, GAP.
REQ-014 IDLE: if req_i != 0, the arbiter shall pick a winner, register word_o and go to START next cycle; else stay.
REQ-015 word_o shall be {ch, 1'b0 (BUF), 1'b1 (GA=1x), 1'b1 (SHDN off), code}; ch = 0 for A, 1 for B; code zero-extended/truncated to 12 bits.
REQ-016 START: start_o shall be high for exactly this one cycle, then go to WAIT.
REQ-017 WAIT: word_o shall be held stable; on eod_i = 1, ack_o[winner] shall pulse one cycle and FSM go to GAP.
REQ-018 eod_i outside WAIT shall be ignored.
REQ-019 GAP: an 8-bit counter shall count GAP_CYC cycles, then FSM returns to IDLE.
REQ-020 Latency req_i rise (FSM in IDLE) -> start_o = 2 cycles; eod_i -> ack_o = 1 cycle.
REQ-021 A request deasserted before grant shall be dropped; one deasserted after grant shall still complete and ack.
REQ-022 A request still high in the cycle after its ack shall be treated as a new request.
REQ-023 Both requests in the same IDLE cycle: winner per REQ-029/REQ-030; loser stays pending and is served next.

Reset
REQ-024 On rst_i = 0, FSM shall go to IDLE immediately, asynchronously.
REQ-025 Reset values: start_o = 0, word_o = 16'h0000, ack_o = 2'b00, busy_o = 0, gap counter = 0, last-grant pointer = ch B (so ch A wins first).
REQ-026 Reset mid-frame shall abort with no ack; the pending request is re-served after release.
REQ-027 No output shall glitch high in the first cycle after reset release.

Configuration
REQ-028 Macro DAC_RR_ARB_EN shall select the arbitration policy.
REQ-029 With DAC_RR_ARB_EN defined: round-robin; on simultaneous requests the channel not granted last wins; the pointer updates on every grant.
REQ-030 Without it: fixed priority, ch A always wins; the pointer logic shall be absent.

Verification
REQ-031 req_i = 01, data0_i = 12'hABC -> start_o at cycle +2, word_o = 16'h3ABC; eod_i pulse -> ack_o = 01 next cycle; busy_o low GAP_CYC cycles later.
REQ-032 req_i = 11, data0 = 12'h100, data1 = 12'h200, RR enabled -> frames 16'h3100 then 16'hB200, acks 01 then 10, second start_o exactly GAP_CYC + 2 cycles after first ack.
REQ-033 req_i held 11 for 4 frames: RR gives A,B,A,B; fixed priority gives A,A,A,A.
REQ-034 rst_i low for 1 cycle during WAIT with req_i = 10 -> no ack; after release, a new frame 16'hB??? starts at cycle +2.
REQ-035 eod_i pulsed while in IDLE and GAP -> no ack_o, no state change.
REQ-036 req_i = 01 dropped after 1 cycle in IDLE (granted) -> frame completes, ack_o = 01; dropped while FSM busy on ch B -> no ch A frame.
